// File: rtl/reset_seq_pkg.sv
// Shared types and helpers for the reset release sequencer.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    SYNC,
    RUN,
    DONE
  } state_e;

  // Width needed to hold values below 'value', never less than one bit.
  function automatic int unsigned clog2_min1(input int unsigned value);
    return (value <= 1) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/reset_sync_chain.sv
// Asynchronous-assert, synchronous-deassert reset synchronizer of DEPTH stages.
module reset_sync_chain #(
  parameter int unsigned DEPTH = 3
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_sync
);

  logic [DEPTH-1:0] r_chain;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_chain <= '0;
    end else begin
      r_chain <= {r_chain[DEPTH-2:0], 1'b1};
    end
  end

  assign o_sync = r_chain[DEPTH-1];

endmodule

// File: rtl/reset_sync_sequencer.sv
// Multi-channel reset synchronizer that releases downstream resets one at a time,
// STRETCH cycles apart, with a synchronous software restart.
module reset_sync_sequencer
  import reset_seq_pkg::*;
#(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned DEPTH    = 3,
  parameter int unsigned STRETCH  = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                io_sw_rst,
  output logic [CHANNELS-1:0] io_q,
  output logic                io_done
);

  if (CHANNELS < 1) begin : g_bad_channels
    $fatal(1, "reset_sync_sequencer: CHANNELS must be at least 1");
  end
  if (DEPTH < 2) begin : g_bad_depth
    $fatal(1, "reset_sync_sequencer: DEPTH must be at least 2");
  end
  if (STRETCH < 1) begin : g_bad_stretch
    $fatal(1, "reset_sync_sequencer: STRETCH must be at least 1");
  end

  localparam int unsigned CntW = clog2_min1(STRETCH);
  localparam int unsigned IdxW = clog2_min1(CHANNELS + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(STRETCH - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(CHANNELS - 1);

  logic                w_sync;
  logic                w_step;
  state_e              r_state;
  logic [CntW-1:0]     r_cnt;
  logic [IdxW-1:0]     r_idx;
  logic [CHANNELS-1:0] r_q;
  logic                r_done;

  reset_sync_chain #(
    .DEPTH(DEPTH)
  ) u_chain (
    .i_clk  (clock),
    .i_rst_n(reset),
    .o_sync (w_sync)
  );

  // The edge that first sees the synchronized reset high already counts toward
  // the first stretch interval, so channel k releases after edge DEPTH+(k+1)*STRETCH.
  always_comb begin
    w_step = 1'b0;
    unique case (r_state)
      SYNC:    w_step = w_sync;
      RUN:     w_step = 1'b1;
      DONE:    w_step = 1'b0;
      default: w_step = 1'b0;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= SYNC;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_q     <= '0;
      r_done  <= 1'b0;
    end else if (io_sw_rst) begin
      r_state <= RUN;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_q     <= '0;
      r_done  <= 1'b0;
    end else if (w_step) begin
      r_state <= RUN;
      if (r_cnt == CntLast) begin
        r_cnt <= '0;
        r_idx <= r_idx + 1'b1;
        // Releases are strictly ascending, so shifting in a one sets bit idx.
        r_q   <= (r_q << 1) | CHANNELS'(1);
        if (r_idx == IdxLast) begin
          r_state <= DONE;
          r_done  <= 1'b1;
        end
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign io_q    = r_q;
  assign io_done = r_done;

endmodule

// File: tb/tb_reset_sync_sequencer.sv
// Checks three parameterisations of the reset sequencer against a timing model
// derived from edge counts since the last reset release or software restart.
module tb_reset_sync_sequencer;

  logic       clock;
  logic       reset;
  logic       io_sw_rst;
  logic [3:0] qa;
  logic       done_a;
  logic [3:0] qb;
  logic       done_b;
  logic [0:0] qc;
  logic       done_c;

  int vectors;
  int miscompares;
  int n_edges;      // edges since the origin event
  bit from_reset;   // origin was a reset release (true) or a software restart

  reset_sync_sequencer #(.CHANNELS(4), .DEPTH(3), .STRETCH(8)) u_dut_a (
    .clock(clock), .reset(reset), .io_sw_rst(io_sw_rst), .io_q(qa), .io_done(done_a)
  );
  reset_sync_sequencer #(.CHANNELS(4), .DEPTH(2), .STRETCH(1)) u_dut_b (
    .clock(clock), .reset(reset), .io_sw_rst(io_sw_rst), .io_q(qb), .io_done(done_b)
  );
  reset_sync_sequencer #(.CHANNELS(1), .DEPTH(3), .STRETCH(5)) u_dut_c (
    .clock(clock), .reset(reset), .io_sw_rst(io_sw_rst), .io_q(qc), .io_done(done_c)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic int released(input int c, input int d, input int s);
    int ticks;
    int rel;
    ticks = from_reset ? n_edges - d : n_edges;
    if (!reset) ticks = -1;
    rel = (ticks < 0) ? 0 : ticks / s;
    if (rel > c) rel = c;
    return rel;
  endfunction

  function automatic logic [3:0] ones(input int rel);
    logic [4:0] v;
    v = (5'd1 << rel) - 5'd1;
    return v[3:0];
  endfunction

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s at t=%0t observed=%b expected=%b", tag, $time, obs, exp);
    end
  endtask

  task automatic check_all();
    int ra;
    int rb;
    int rc;
    ra = released(4, 3, 8);
    rb = released(4, 2, 1);
    rc = released(1, 3, 5);
    check("a_q", qa, ones(ra));
    check("a_done", {3'b0, done_a}, {3'b0, ra == 4});
    check("b_q", qb, ones(rb));
    check("b_done", {3'b0, done_b}, {3'b0, rb == 4});
    check("c_q", {3'b0, qc}, ones(rc));
    check("c_done", {3'b0, done_c}, {3'b0, rc == 1});
  endtask

  // Applies sw for one edge, advances the model, checks 1 ns after the edge.
  task automatic step(input logic sw);
    io_sw_rst = sw;
    @(posedge clock);
    if (!reset) begin
      n_edges = 0;
      from_reset = 1'b1;
    end else if (sw) begin
      n_edges = 0;
      from_reset = 1'b0;
    end else if (n_edges < 10000) begin
      n_edges++;
    end
    #1;
    check_all();
  endtask

  task automatic steps(input int count);
    for (int i = 0; i < count; i++) step(1'b0);
  endtask

  // Sub-period reset pulse between edges; outputs must clear without a clock.
  task automatic pulse_reset();
    #2 reset = 1'b0;
    n_edges = 0;
    from_reset = 1'b1;
    #1;
    check_all();
    check("async_clear_a", qa, 4'b0000);
    #2 reset = 1'b1;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    n_edges = 0;
    from_reset = 1'b1;
    reset = 1'b0;
    io_sw_rst = 1'b0;
    #1;
    check_all();
    step(1'b0);
    step(1'b0);
    #2 reset = 1'b1;

    // Power-on release; the model counts edge 1 as the next rising edge.
    for (int e = 1; e <= 39; e++) begin
      step(1'b0);
      if (e == 10) check("a_edge10", qa, 4'b0000);
      if (e == 11) check("a_edge11", qa, 4'b0001);
      if (e == 35) check("a_done35", {3'b0, done_a}, 4'b0001);
      if (e == 5)  check("b_edge5", qb, 4'b0111);
      if (e == 7)  check("c_edge7", {3'b0, qc}, 4'b0000);
      if (e == 8)  check("c_edge8", {3'b0, qc}, 4'b0001);
    end

    // Software restart held for edges 40..42.
    step(1'b1);
    check("sw_clear_a", {done_a, qa[2:0]}, 4'b0000);
    step(1'b1);
    step(1'b1);
    for (int e = 43; e <= 75; e++) begin
      step(1'b0);
      if (e == 49) check("sw_edge49", qa, 4'b0000);
      if (e == 50) check("sw_edge50", qa, 4'b0001);
      if (e == 74) check("sw_edge74", qa, 4'b1111);
    end

    // Restart from a fresh reset, then a short reset pulse at edge 22.
    pulse_reset();
    steps(22);
    check("pre_pulse_a", qa, 4'b0011);
    pulse_reset();
    steps(36);

    // Software restart while reset is low: reset dominates.
    #2 reset = 1'b0;
    n_edges = 0;
    from_reset = 1'b1;
    step(1'b1);
    step(1'b1);
    step(1'b1);
    io_sw_rst = 1'b0;
    #2 reset = 1'b1;
    steps(36);

    // Random mix of software restarts, reset pulses and idle edges.
    for (int i = 0; i < 600; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 3) pulse_reset();
      else if (r < 9) step(1'b1);
      else step(1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
